axi_ram_rd: RTL and testbench
=============================

# axi_ram_rd

Single-port AXI4 read-only RAM slave that terminates one master-side read port of the AXI read crossbar (m_axi_ar*/m_axi_r*). It accepts one AR burst at a time, generates FIXED/INCR/WRAP beat addresses, and returns R beats from an internal word-addressed RAM at one beat per clock under backpressure. A simple side write port loads RAM contents for system bring-up and test.

## Interface
- DATA_WIDTH, 32, RAM word and R data width; multiple of 8.
- ADDR_WIDTH, 16, byte address width; RAM depth = 2^ADDR_WIDTH / STRB_WIDTH words.
- STRB_WIDTH, DATA_WIDTH/8, byte lanes per word.
- ID_WIDTH, 10, AR/R ID width; matches crossbar M_IF_ID_WIDTH (8 + clog2(4)).
- clk  in  1  single clock; everything on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axi_arid  in  ID_WIDTH  burst ID.
- s_axi_araddr  in  ADDR_WIDTH  start byte address.
- s_axi_arlen  in  8  beats minus one.
- s_axi_arsize  in  3  log2 bytes per beat.
- s_axi_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- s_axi_arlock  in  1  exclusive request; ignored (no exclusive support, normal OKAY).
- s_axi_arqos  in  4  ignored.
- s_axi_arvalid / s_axi_arready  in / out  1  AR handshake.
- s_axi_rid  out  ID_WIDTH  echoes arid.
- s_axi_rdata  out  DATA_WIDTH  full word, all lanes.
- s_axi_rresp  out  2  00 OKAY, 10 SLVERR.
- s_axi_rlast  out  1  final beat.
- s_axi_rvalid / s_axi_rready  out / in  1  R handshake.
- ram_wr_en  in  1  side write strobe.
- ram_wr_addr  in  ADDR_WIDTH-log2(STRB_WIDTH)  word address.
- ram_wr_data  in  DATA_WIDTH  write data.
- ram_wr_strb  in  STRB_WIDTH  byte enables.

## Operation
- States: IDLE, BURST. arready = 1 only in IDLE and not in rst.
- IDLE: on arvalid&arready latch id, addr, len, size, burst; beat counter = len; error flag = (arsize > log2(STRB_WIDTH)) | (arburst == 11) | (arburst == WRAP & arlen not in {1,3,7,15}); go BURST.
- BURST: issue one RAM read per cycle when the output stage has room; after issuing the beat with counter 0, return to IDLE.
- Address step: INCR/reserved: addr += 1<<size. FIXED: addr unchanged. WRAP: boundary = (len+1)<<size; addr = (addr & ~(boundary-1)) | ((addr + (1<<size)) & (boundary-1)). Arithmetic is ADDR_WIDTH bits; INCR past the top of RAM wraps modulo 2^ADDR_WIDTH.
- RAM word index = addr >> log2(STRB_WIDTH). Unaligned start address: rdata is the full containing word.
- Error flag set: every beat has rresp = SLVERR; len+1 beats are still returned; rdata is the RAM word at the generated address.
- Side write is independent of the read path. Write and read of the same word in the same cycle: the read returns the old data.
- RAM contents are not reset.

## Timing
- Reset values: arready 0, rvalid 0, rlast 0, rresp 0, rid 0, rdata 0. The first arready = 1 is in the cycle after rst deasserts.
- AR handshake at edge N: RAM read at edge N+1; beat 0 rvalid from N+2.
- With rready held high: one beat per cycle. The next arready = 1 is in the cycle after the last read is issued.
- Output is a 2-entry skid (output register plus one spill) so that rready low never loses a beat. Read issue stalls when both entries are full or one is full with a read in flight.
- R outputs hold stable while rvalid & !rready.
- rst mid-burst: the burst is abandoned, pending beats are dropped, and all outputs return to reset values at the next edge.

## Structure
- Package axi_pkg holds the burst encodings (FIXED/INCR/WRAP), the resp encodings (OKAY/SLVERR), and a log2-bytes helper function.
- Sub-module axi_rd_addr_gen: combinational next-address function of (addr, size, len, burst), reusable by a future write-side RAM.
- RAM is an inferred array with a registered read.

## Test plan
- Write words 0..15 with value = 0x1000+index. AR addr 0x08, len 0, size 2, INCR, id 0x155 -> one beat, rdata 0x1002, rresp 00, rlast 1, rid 0x155, rvalid first at N+2.
- AR addr 0x00, len 3, size 2, INCR, rready high -> four consecutive beats 0x1000..0x1003, rlast only on beat 3.
- AR addr 0x0C, len 3, size 2, WRAP -> data 0x1003, 0x1000, 0x1001, 0x1002. AR addr 0x04, len 2, WRAP -> three beats, all SLVERR.
- AR addr 0x00, len 7, INCR, rready toggled randomly -> eight beats, in order, no loss or duplication, outputs stable while stalled.
- AR size 3 with DATA_WIDTH 32 -> len+1 beats, all SLVERR. AR burst 11 -> SLVERR. FIXED len 3 at 0x04 -> 0x1001 four times.
- rst asserted at beat 2 of a len-7 burst -> rvalid 0 next edge, arready 1 after release, and a following single-beat read returns correct data.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI encodings and helpers for the RAM slave read path and its future
// write-side sibling.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } axi_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    // Number of address bits that select a byte inside a word of 'bytes' lanes.
    function automatic int unsigned log2_bytes(input int unsigned bytes);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < bytes) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_rd_addr_gen.sv
// Combinational AXI beat-address stepper: given the current beat address and the
// burst attributes, returns the address of the following beat.
module axi_rd_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [2:0]            size_i,
    input  logic [7:0]            len_i,
    input  axi_burst_e            burst_i,
    output logic [ADDR_WIDTH-1:0] next_addr_o
);

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    assign step      = ADDR_WIDTH'(1) << size_i;
    // Wrap window is the whole burst footprint; the mask keeps the low bits moving.
    assign wrap_mask = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);

    always_comb begin
        next_addr_o = addr_i + step;
        unique case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask) | ((addr_i + step) & wrap_mask);
            default:     next_addr_o = addr_i + step;
        endcase
    end

endmodule

// File: rtl/axi_ram_rd.sv
// AXI4 read-only RAM slave: one burst at a time, registered RAM read, and a
// two-entry output skid so R backpressure never drops a beat.
module axi_ram_rd
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 10
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [ID_WIDTH-1:0]                           s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]                         s_axi_araddr,
    input  logic [7:0]                                    s_axi_arlen,
    input  logic [2:0]                                    s_axi_arsize,
    input  logic [1:0]                                    s_axi_arburst,
    input  logic                                          s_axi_arlock,
    input  logic [3:0]                                    s_axi_arqos,
    input  logic                                          s_axi_arvalid,
    output logic                                          s_axi_arready,
    output logic [ID_WIDTH-1:0]                           s_axi_rid,
    output logic [DATA_WIDTH-1:0]                         s_axi_rdata,
    output logic [1:0]                                    s_axi_rresp,
    output logic                                          s_axi_rlast,
    output logic                                          s_axi_rvalid,
    input  logic                                          s_axi_rready,
    input  logic                                          ram_wr_en,
    input  logic [ADDR_WIDTH-log2_bytes(STRB_WIDTH)-1:0] ram_wr_addr,
    input  logic [DATA_WIDTH-1:0]                         ram_wr_data,
    input  logic [STRB_WIDTH-1:0]                         ram_wr_strb
);

    localparam int WORD_LSB  = log2_bytes(STRB_WIDTH);
    localparam int RAM_WORDS = 2 ** (ADDR_WIDTH - WORD_LSB);

    typedef enum logic {ST_IDLE, ST_BURST} state_e;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
        axi_resp_e             resp;
        logic                  last;
    } beat_t;

    state_e                state_q;
    logic                  arready_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [7:0]            cnt_q;
    logic [2:0]            size_q;
    axi_burst_e            burst_q;
    logic                  err_q;

    logic                  rd_valid_q;
    logic [ID_WIDTH-1:0]   rd_id_q;
    axi_resp_e             rd_resp_q;
    logic                  rd_last_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] mem [RAM_WORDS];

    beat_t out_q, out_d, skid_q, skid_d, in_beat;
    logic  out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;

    logic                  ar_hs, ar_err, pop, issue;
    logic [1:0]            occ;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  unused_ok;

    assign unused_ok = &{1'b0, s_axi_arlock, s_axi_arqos};

    assign ar_hs  = s_axi_arvalid && arready_q;
    assign ar_err = (s_axi_arsize > 3'(WORD_LSB)) || (s_axi_arburst == BURST_RSVD) ||
                    ((s_axi_arburst == BURST_WRAP) &&
                     !(s_axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));

    // Entries held after this cycle's pop, plus the read already in flight.
    assign pop   = out_valid_q && s_axi_rready;
    assign occ   = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(rd_valid_q) - 2'(pop);
    assign issue = (state_q == ST_BURST) && (occ < 2'd2);

    axi_rd_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .addr_i      (addr_q),
        .size_i      (size_q),
        .len_i       (len_q),
        .burst_i     (burst_q),
        .next_addr_o (next_addr)
    );

    // NOTE: sequential state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            arready_q <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            size_q    <= '0;
            burst_q   <= BURST_INCR;
            err_q     <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs) begin
                        id_q      <= s_axi_arid;
                        addr_q    <= s_axi_araddr;
                        len_q     <= s_axi_arlen;
                        cnt_q     <= s_axi_arlen;
                        size_q    <= s_axi_arsize;
                        burst_q   <= axi_burst_e'(s_axi_arburst);
                        err_q     <= ar_err;
                        arready_q <= 1'b0;
                        state_q   <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (issue) begin
                        addr_q <= next_addr;
                        cnt_q  <= cnt_q - 8'd1;
                        if (cnt_q == 8'd0) begin
                            state_q   <= ST_IDLE;
                            arready_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_id_q    <= '0;
            rd_resp_q  <= RESP_OKAY;
            rd_last_q  <= 1'b0;
        end else begin
            rd_valid_q <= issue;
            if (issue) begin
                rd_id_q   <= id_q;
                rd_resp_q <= err_q ? RESP_SLVERR : RESP_OKAY;
                rd_last_q <= (cnt_q == 8'd0);
            end
        end
    end

    // NOTE: the RAM array and its read register carry no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (ram_wr_en) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (ram_wr_strb[b]) mem[ram_wr_addr][8*b +: 8] <= ram_wr_data[8*b +: 8];
            end
        end
        if (issue) rd_data_q <= mem[addr_q[ADDR_WIDTH-1:WORD_LSB]];
    end

    assign in_beat = '{id: rd_id_q, data: rd_data_q, resp: rd_resp_q, last: rd_last_q};

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (!out_valid_q || pop) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = rd_valid_q;
                if (rd_valid_q) skid_d = in_beat;
            end else begin
                out_valid_d = rd_valid_q;
                if (rd_valid_q) out_d = in_beat;
            end
        end else if (rd_valid_q) begin
            skid_d       = in_beat;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = out_valid_q;
    assign s_axi_rid     = out_q.id;
    assign s_axi_rdata   = out_q.data;
    assign s_axi_rresp   = out_q.resp;
    assign s_axi_rlast   = out_q.last;

endmodule

// File: tb/tb_axi_ram_rd.sv
// Scoreboard bench for axi_ram_rd: bursts are expanded by a reference model into
// expected beats; an independent monitor compares every R handshake.
module tb_axi_ram_rd;

    typedef struct {
        logic [9:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst;
    logic [9:0]  s_axi_arid;
    logic [15:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_arlock;
    logic [3:0]  s_axi_arqos;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [9:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic        ram_wr_en;
    logic [13:0] ram_wr_addr;
    logic [31:0] ram_wr_data;
    logic [3:0]  ram_wr_strb;

    logic [31:0] model [16384];
    beat_t       exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          beats_seen = 0;
    bit          rr_random = 0;
    bit          stalled = 0;
    logic [44:0] snap;

    axi_ram_rd dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_arid    (s_axi_arid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arsize  (s_axi_arsize),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arlock  (s_axi_arlock),
        .s_axi_arqos   (s_axi_arqos),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .ram_wr_en     (ram_wr_en),
        .ram_wr_addr   (ram_wr_addr),
        .ram_wr_data   (ram_wr_data),
        .ram_wr_strb   (ram_wr_strb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Expand one AR request into its beats using the address rules directly.
    task automatic push_burst(input logic [9:0] id, input logic [15:0] addr,
                              input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        logic [15:0] a, bnd, stp;
        bit          err;
        beat_t       b;
        err = (size > 3'd2) || (burst == 2'b11) ||
              ((burst == 2'b10) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
        a   = addr;
        stp = 16'd1 << size;
        bnd = (16'(len) + 16'd1) << size;
        for (int i = 0; i <= int'(len); i++) begin
            b.id   = id;
            b.data = model[a[15:2]];
            b.resp = err ? 2'b10 : 2'b00;
            b.last = (i == int'(len));
            exp_q.push_back(b);
            if (burst == 2'b00)      a = a;
            else if (burst == 2'b10) a = (a & ~(bnd - 16'd1)) | ((a + stp) & (bnd - 16'd1));
            else                     a = a + stp;
        end
    endtask

    task automatic ram_write(input logic [13:0] wa, input logic [31:0] d, input logic [3:0] strb);
        ram_wr_en   = 1'b1;
        ram_wr_addr = wa;
        ram_wr_data = d;
        ram_wr_strb = strb;
        @(posedge clk);
        #1;
        ram_wr_en = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) model[wa][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // Returns one time unit after the handshake edge.
    task automatic send_ar(input logic [9:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit done;
        done          = 0;
        s_axi_arid    = id;
        s_axi_araddr  = addr;
        s_axi_arlen   = len;
        s_axi_arsize  = size;
        s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk);
            if (s_axi_arready) begin
                @(posedge clk);
                #1;
                s_axi_arvalid = 1'b0;
                push_burst(id, addr, len, size, burst);
                done = 1;
            end
        end
        if (!done) begin
            s_axi_arvalid = 1'b0;
            check("ar_handshake_timeout", 64'(done), 64'd1);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 3000 && exp_q.size() != 0; k++) @(posedge clk);
        check(name, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            s_axi_rready = rr_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 0;
                continue;
            end
            if (stalled) begin
                check("hold_rvalid", 64'(s_axi_rvalid), 64'd1);
                check("hold_fields", 64'({s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast}), 64'(snap));
            end
            if (s_axi_rvalid && s_axi_rready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(s_axi_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("rid",   64'(s_axi_rid),   64'(e.id));
                    check("rdata", 64'(s_axi_rdata), 64'(e.data));
                    check("rresp", 64'(s_axi_rresp), 64'(e.resp));
                    check("rlast", 64'(s_axi_rlast), 64'(e.last));
                end
                beats_seen++;
            end
            stalled = s_axi_rvalid && !s_axi_rready;
            snap    = {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast};
        end
    end

    initial begin
        int base;
        rst = 1'b1;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
        s_axi_arburst = '0; s_axi_arlock = 1'b0; s_axi_arqos = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b1;
        ram_wr_en = 1'b0; ram_wr_addr = '0; ram_wr_data = '0; ram_wr_strb = '0;
        for (int i = 0; i < 16384; i++) model[i] = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_arready", 64'(s_axi_arready), 64'd0);
        check("reset_rvalid",  64'(s_axi_rvalid),  64'd0);
        check("reset_fields",  64'({s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast}), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("arready_after_reset", 64'(s_axi_arready), 64'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) ram_write(14'(i), 32'h1000 + 32'(i), 4'hF);
        for (int i = 16; i < 256; i++) ram_write(14'(i), $urandom, 4'hF);
        ram_write(14'd20, 32'hAABBCCDD, 4'b0101);
        ram_write(14'd16383, 32'hDEADBEEF, 4'hF);

        // Single beat with latency check.
        send_ar(10'h155, 16'h0008, 8'd0, 3'd2, 2'b01);
        @(negedge clk);
        check("lat_rvalid_n0", 64'(s_axi_rvalid), 64'd0);
        @(negedge clk);
        check("lat_rvalid_n1", 64'(s_axi_rvalid), 64'd0);
        @(negedge clk);
        check("lat_rvalid_n2", 64'(s_axi_rvalid), 64'd1);
        wait_drain("drain_single");

        // Four-beat INCR; arready returns the cycle after the last issue.
        send_ar(10'h011, 16'h0000, 8'd3, 3'd2, 2'b01);
        repeat (4) @(negedge clk);
        check("arready_busy", 64'(s_axi_arready), 64'd0);
        @(negedge clk);
        check("arready_again", 64'(s_axi_arready), 64'd1);
        wait_drain("drain_incr4");

        send_ar(10'h022, 16'h000C, 8'd3, 3'd2, 2'b10);
        wait_drain("drain_wrap4");
        send_ar(10'h023, 16'h0004, 8'd2, 3'd2, 2'b10);
        wait_drain("drain_wrap_bad_len");

        rr_random = 1;
        send_ar(10'h033, 16'h0000, 8'd7, 3'd2, 2'b01);
        wait_drain("drain_backpressure");
        rr_random = 0;

        send_ar(10'h044, 16'h0000, 8'd3, 3'd3, 2'b01);
        wait_drain("drain_bad_size");
        send_ar(10'h045, 16'h0010, 8'd1, 3'd2, 2'b11);
        wait_drain("drain_rsvd_burst");
        send_ar(10'h046, 16'h0004, 8'd3, 3'd2, 2'b00);
        wait_drain("drain_fixed");
        send_ar(10'h047, 16'hFFFC, 8'd1, 3'd2, 2'b01);
        wait_drain("drain_addr_rollover");

        // Same-cycle write and read of one word: read sees old contents.
        send_ar(10'h050, 16'h0014, 8'd0, 3'd2, 2'b01);
        ram_write(14'd5, 32'hABCD0005, 4'hF);
        wait_drain("drain_collision_old");
        send_ar(10'h051, 16'h0014, 8'd0, 3'd2, 2'b01);
        wait_drain("drain_collision_new");

        rr_random = 1;
        for (int t = 0; t < 30; t++) begin
            send_ar(10'($urandom), 16'($urandom_range(0, 16'h02FF)), 8'($urandom_range(0, 15)),
                    3'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end
        wait_drain("drain_random");
        rr_random = 0;

        // Reset in the middle of a burst.
        send_ar(10'h066, 16'h0000, 8'd7, 3'd2, 2'b01);
        base = beats_seen;
        for (int k = 0; k < 200 && beats_seen < base + 2; k++) @(posedge clk);
        check("rst_reach_beat2", 64'(beats_seen >= base + 2), 64'd1);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("midrst_rvalid",  64'(s_axi_rvalid),  64'd0);
        check("midrst_arready", 64'(s_axi_arready), 64'd0);
        check("midrst_fields",  64'({s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_arready_release", 64'(s_axi_arready), 64'd1);
        @(posedge clk);
        #1;
        send_ar(10'h077, 16'h003C, 8'd0, 3'd2, 2'b01);
        wait_drain("drain_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
